// File: rtl/input_sr.sv
// rtl/input_sr.sv - 2-wire bit/clock link receiver: MSB-first bytes onto a valid/ready interface
// Synchronises the line, shifts on sclk rising edges, recovers framing on overrun and idle timeout.
module input_sr #(
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_bit,
  input  logic       i_sclk,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_overrun,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] bit_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic                   prev_sclk;
  logic                   sync_bit;
  logic                   sync_sclk;
  logic                   sclk_edge;
  logic [6:0]             sr;
  logic [2:0]             bit_cnt;
  logic [7:0]             idle_cnt;
  logic                   byte_done;
  logic                   timeout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bit_sync  <= '0;
      sclk_sync <= '0;
      prev_sclk <= 1'b0;
    end else begin
      bit_sync[0]  <= i_bit;
      sclk_sync[0] <= i_sclk;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        bit_sync[i]  <= bit_sync[i-1];
        sclk_sync[i] <= sclk_sync[i-1];
      end
      prev_sclk <= sync_sclk;
    end
  end

  assign sync_bit  = bit_sync[SYNC_STAGES-1];
  assign sync_sclk = sclk_sync[SYNC_STAGES-1];
  assign sclk_edge = sync_sclk & ~prev_sclk;
  assign byte_done = sclk_edge && (bit_cnt == 3'd7);
  assign timeout   = !sclk_edge && (bit_cnt != 3'd0) && (idle_cnt == IDLE_LAST);

  // Only seven bits are kept: the eighth arrives with the completing edge and goes straight to o_data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sr       <= '0;
      bit_cnt  <= '0;
      idle_cnt <= '0;
    end else if (sclk_edge) begin
      sr       <= {sr[5:0], sync_bit};
      bit_cnt  <= bit_cnt + 3'd1;
      idle_cnt <= '0;
    end else if (timeout) begin
      sr       <= '0;
      bit_cnt  <= '0;
      idle_cnt <= '0;
    end else if (bit_cnt != 3'd0) begin
      if (idle_cnt != 8'hFF) begin
        idle_cnt <= idle_cnt + 8'd1;
      end
    end else begin
      idle_cnt <= '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_overrun   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_overrun   <= byte_done && o_valid && !i_ready;
      o_frame_err <= timeout;
      if (byte_done) begin
        o_data  <= {sr, sync_bit};
        o_valid <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  assign o_busy = (bit_cnt != 3'd0);

endmodule

// File: tb/tb_input_sr.sv
// tb/tb_input_sr.sv - directed bench for input_sr
module tb_input_sr;

  localparam int SYNC_STAGES  = 2;
  localparam int IDLE_TIMEOUT = 8;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_bit = 1'b0;
  logic       i_sclk = 1'b0;
  logic       i_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_overrun;
  logic       o_frame_err;
  logic       o_busy;

  input_sr #(.SYNC_STAGES(SYNC_STAGES), .IDLE_TIMEOUT(IDLE_TIMEOUT)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_bit      (i_bit),
    .i_sclk     (i_sclk),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_overrun  (o_overrun),
    .o_frame_err(o_frame_err),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_data;
    int         exp_busy;
  } vec_t;

  vec_t       vecs[5];
  int         checks = 0;
  int         failures = 0;
  int         valid_cycles;
  int         ovr_pulses;
  int         fe_pulses;
  int         busy_cycles;
  logic [7:0] last_data;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    valid_cycles = 0;
    ovr_pulses   = 0;
    fe_pulses    = 0;
    busy_cycles  = 0;
    last_data    = 8'h00;
  endtask

  // Advance one clock and sample outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
    if (o_valid) begin
      valid_cycles++;
      last_data = o_data;
    end
    if (o_overrun)   ovr_pulses++;
    if (o_frame_err) fe_pulses++;
    if (o_busy)      busy_cycles++;
  endtask

  // Sends n bits MSB first from b, one cycle per sclk phase; sclk is left high.
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int k = 7; k > 7 - n; k--) begin
      i_bit  = b[k];
      i_sclk = 1'b0;
      tick();
      i_sclk = 1'b1;
      tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
    i_sclk = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!o_valid && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_valid_timeout"}, int'(o_valid), 1);
  endtask

  initial begin
    int ok;
    int fe_at;

    vecs[0] = '{8'hA5, 8'hA5, 14};
    vecs[1] = '{8'h00, 8'h00, 14};
    vecs[2] = '{8'hFF, 8'hFF, 14};
    vecs[3] = '{8'h5A, 8'h5A, 14};
    vecs[4] = '{8'h81, 8'h81, 14};

    clear_mon();
    repeat (3) tick();
    chk("rst_data", int'(o_data), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_overrun", int'(o_overrun), 0);
    chk("rst_frame_err", int'(o_frame_err), 0);
    chk("rst_busy", int'(o_busy), 0);
    i_rst_n = 1'b1;
    repeat (2) tick();

    i_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      clear_mon();
      send_byte(vecs[v].din);
      repeat (6) tick();
      chk($sformatf("vec%0d_valid_cycles", v), valid_cycles, 1);
      chk($sformatf("vec%0d_data", v), int'(last_data), int'(vecs[v].exp_data));
      chk($sformatf("vec%0d_busy_cycles", v), busy_cycles, vecs[v].exp_busy);
      chk($sformatf("vec%0d_overrun", v), ovr_pulses, 0);
    end

    // Backpressure
    clear_mon();
    i_ready = 1'b0;
    send_byte(8'h3C);
    wait_valid("bp");
    ok = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (!o_valid || o_data != 8'h3C) ok = 0;
    end
    chk("bp_hold", ok, 1);
    i_ready = 1'b1;
    tick();
    chk("bp_valid_after_accept", int'(o_valid), 0);
    chk("bp_data_kept", int'(o_data), 8'h3C);
    chk("bp_overrun", ovr_pulses, 0);

    // Overrun
    clear_mon();
    i_ready = 1'b0;
    send_byte(8'h12);
    send_byte(8'h34);
    repeat (5) tick();
    chk("ovr_data", int'(o_data), 8'h34);
    chk("ovr_valid", int'(o_valid), 1);
    chk("ovr_pulses", ovr_pulses, 1);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;

    // Completion coincident with accept
    send_byte(8'h96);
    wait_valid("coin_first");
    clear_mon();
    send_bits(8'hC3, 8);
    i_sclk = 1'b0;
    tick();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk("coin_valid", int'(o_valid), 1);
    chk("coin_data", int'(o_data), 8'hC3);
    chk("coin_overrun_now", int'(o_overrun), 0);
    tick();
    chk("coin_valid_held", int'(o_valid), 1);
    chk("coin_overrun_total", ovr_pulses, 0);
    i_ready = 1'b1;
    tick();

    // Idle timeout
    clear_mon();
    send_bits(8'hA0, 3);
    i_sclk = 1'b0;
    fe_at = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (o_frame_err && fe_at < 0) fe_at = c;
    end
    chk("idle_fe_pulses", fe_pulses, 1);
    chk("idle_fe_time", fe_at, SYNC_STAGES + IDLE_TIMEOUT);
    chk("idle_busy_low", int'(o_busy), 0);
    chk("idle_no_valid", valid_cycles, 0);
    clear_mon();
    send_byte(8'h81);
    repeat (6) tick();
    chk("idle_next_data", int'(last_data), 8'h81);
    chk("idle_next_valid_cycles", valid_cycles, 1);

    // Asynchronous reset mid-byte with a byte pending
    i_ready = 1'b0;
    send_byte(8'h55);
    wait_valid("ar_pending");
    send_bits(8'hFF, 5);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("ar_data", int'(o_data), 0);
    chk("ar_valid", int'(o_valid), 0);
    chk("ar_overrun", int'(o_overrun), 0);
    chk("ar_frame_err", int'(o_frame_err), 0);
    chk("ar_busy", int'(o_busy), 0);
    i_sclk = 1'b0;
    repeat (2) tick();
    i_rst_n = 1'b1;
    tick();
    clear_mon();
    i_ready = 1'b1;
    send_byte(8'hF0);
    repeat (6) tick();
    chk("ar_next_data", int'(last_data), 8'hF0);
    chk("ar_next_valid_cycles", valid_cycles, 1);
    chk("ar_next_frame_err", fe_pulses, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_sr.md
Name: input_sr

Overview:
- Serial-to-parallel receiver for the team's 2-wire bit/clock link (serial data + serial clock, MSB first, 8-bit words).
- Sits on the receiving side of a link driven by an output shift register.
- Synchronises the line, samples data on serial-clock rising edges and assembles bytes.
- Presents each byte on a valid/ready interface, with overrun and idle-timeout framing recovery.

Parameters:
SYNC_STAGES, 2, flops in each input synchroniser (legal 1..3); same depth on i_bit and i_sclk.
IDLE_TIMEOUT, 8, i_clk cycles without a detected sclk edge mid-byte before the partial byte is discarded (legal 2..255).

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_bit  input  1  serial data; valid while i_sclk high
i_sclk  input  1  serial clock; sampled on rising edge
i_ready  input  1  consumer accepts o_data this cycle when o_valid high
o_data  output  8  received byte; stable while o_valid high
o_valid  output  1  byte available; held until accepted
o_overrun  output  1  one-cycle pulse: byte completed while previous byte unaccepted
o_frame_err  output  1  one-cycle pulse: partial byte discarded by idle timeout
o_busy  output  1  high while bit count != 0 (byte in progress)

Behaviour:
- Reset (async assert, sync release): synchronisers, edge-history flop, shift register, bit count, idle count all 0. Outputs: o_data=0, o_valid=0, o_overrun=0, o_frame_err=0, o_busy=0.
- Synchronisers:
  - i_bit and i_sclk each pass through SYNC_STAGES flops.
  - One further flop holds the previous synchronised sclk.
  - edge = sync_sclk & ~prev_sclk.
- Bit capture on edge: sr <= {sr[6:0], sync_bit}; bit count +1 (3-bit, 0..7); idle count cleared.
- Byte completion: edge while bit count == 7.
  - Same clock: o_data <= {sr[6:0], sync_bit}, o_valid <= 1, bit count wraps to 0.
  - Latency: o_valid rises on the SYNC_STAGES-th i_clk edge after the edge that first samples the 8th i_sclk high.
- Handshake:
  - o_valid && i_ready clears o_valid next cycle.
  - o_data holds its value until the next completion.
- Overrun:
  - Completion while o_valid==1 and i_ready==0: o_data overwritten with the new byte, o_valid stays 1, o_overrun pulses 1 cycle.
  - Completion in the same cycle as an accept (o_valid & i_ready): new byte loaded, o_valid stays 1, no overrun.
- Idle timeout:
  - While bit count != 0 and no edge, idle count increments (saturating).
  - When idle count reaches IDLE_TIMEOUT-1 and no edge that cycle: bit count <= 0, sr <= 0, idle count <= 0, o_frame_err pulses 1 cycle.
  - o_valid and o_data are unaffected.
  - When bit count == 0, idle count is held at 0.
- o_busy is combinational: (bit count != 0).
- Minimum link timing: sclk high and low phases each >= 1 i_clk cycle (same-clock transmitter at 1 cycle/phase supported). i_bit must be stable from 1 cycle before to 1 cycle after the sclk rise.
- Reset mid-byte or mid-valid: all state dropped immediately; first edge after release is bit 7 of a new byte.

Test Plan:
- Single byte, SYNC_STAGES=2: drive 0xA5 MSB first, 1 cycle/phase, i_ready=1 -> o_valid high exactly 1 cycle, o_data=0xA5; o_busy high from 1st to 8th detected edge.
- Backpressure: send 0x3C with i_ready=0 for 10 cycles, then 1 -> o_valid stays high, o_data=0x3C throughout; o_valid low the cycle after accept; no o_overrun.
- Overrun: send 0x12 then 0x34 back-to-back, i_ready=0 -> o_data=0x34, o_valid=1, o_overrun single pulse at the 2nd completion.
- Completion coincident with accept: align i_ready=1 to the cycle the 2nd byte (0xC3) completes -> o_valid remains 1, o_data=0xC3, o_overrun=0.
- Idle timeout: 3 sclk pulses, then idle -> o_frame_err pulses once 8 cycles after the last edge, o_busy falls. A following 0x81 is received correctly.
- Async reset: assert i_rst_n low mid-byte (after 5 bits) with o_valid=1 -> all outputs 0 immediately. After release a full 0xF0 is received as 0xF0.
